adc_capture_seq: RTL and testbench
==================================

ADC_CAPTURE_SEQ -- requirements
Module: adc_capture_seq

Interface
REQ-001 Parameter NCH_MAX, default 8: maximum channels per sequence (1..8).
REQ-002 Parameter DATA_W, default 24: ADC sample width, two's complement.
REQ-003 Parameter TIMEOUT_CYC, default 1023: cycles allowed in REQ without ack.
REQ-004 wb_clk_i  in  1  single clock; all logic on rising edge.
REQ-005 wb_rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 ctrl_enable  in  1  level; gates new sequence triggers.
REQ-007 ctrl_start  in  1  one-cycle pulse; manual trigger.
REQ-008 cfg_num_ch  in  4  channels per sequence.
REQ-009 cfg_period  in  16  auto-trigger period in cycles; 0 = auto off.
REQ-010 adc_req_o  out  1  conversion request, level, held until ack.
REQ-011 adc_ch_o  out  3  channel for the current request.
REQ-012 adc_ack_i  in  1  one-cycle ack; adc_data_i valid that cycle.
REQ-013 adc_data_i  in  DATA_W  sample.
REQ-014 raw_we_o  out  1  one-cycle write strobe to the ADC_RAW_CHn register.
REQ-015 raw_ch_o  out  3  target channel for raw_we_o.
REQ-016 raw_data_o  out  32  sample sign-extended to 32 bits.
REQ-017 busy_o  out  1  high whenever state != IDLE.
REQ-018 done_o  out  1  one-cycle pulse on sequence completion.
REQ-019 err_timeout_o  out  1  one-cycle pulse on ack timeout.
REQ-020 seq_cnt_o  out  16  completed-sequence count, wraps 0xFFFF->0.

Function
REQ-021 FSM states IDLE, REQ, WRITE, DONE; the module SHALL hold no other state.
REQ-022 Trigger = ctrl_enable & (ctrl_start | period_tick | pending); in IDLE a trigger sampled at edge T SHALL give adc_req_o=1, adc_ch_o=0 after edge T (REQ state).
REQ-023 At trigger, effective channel count n SHALL latch as: 0->1, >NCH_MAX->NCH_MAX, else cfg_num_ch; it SHALL stay fixed for the sequence.
REQ-024 REQ: adc_req_o held high; ack sampled high -> capture data, go WRITE; adc_req_o low in WRITE.
REQ-025 WRITE: raw_we_o=1 for exactly one cycle with raw_ch_o=ch, raw_data_o=sign-extended capture; ch==n-1 -> DONE else ch+1 -> REQ.
REQ-026 DONE: done_o=1 for one cycle, seq_cnt_o increments, -> IDLE.
REQ-027 Period timer SHALL count 0..cfg_period-1 while ctrl_enable=1 and cfg_period!=0, asserting period_tick at cfg_period-1 and reloading 0; otherwise held at 0.
REQ-028 ctrl_start or period_tick while busy SHALL set a single pending flag (multiple collapse to one); pending cleared when its sequence starts.
REQ-029 ctrl_enable deassertion mid-sequence SHALL NOT abort; the sequence completes; pending flag cleared while ctrl_enable=0.
REQ-030 ctrl_start and period_tick in the same IDLE cycle SHALL start one sequence and leave pending clear.
REQ-031 adc_ack_i outside REQ SHALL be ignored.

Reset
REQ-032 wb_rst_ni low SHALL immediately force IDLE, ch=0, pending=0, timer=0, seq_cnt_o=0, and all outputs 0, including mid-sequence.
REQ-033 Outputs SHALL remain 0 until the first trigger after reset release.

Configuration
REQ-034 Macro HI_ADC_SEQ_TIMEOUT_EN defined: a watchdog counts cycles in REQ; reaching TIMEOUT_CYC without ack SHALL pulse err_timeout_o, drop adc_req_o, return to IDLE, no done_o, seq_cnt_o unchanged, no further raw_we_o.
REQ-035 Macro undefined: REQ waits indefinitely; err_timeout_o tied 0; no watchdog logic.

Verification
REQ-036 cfg_num_ch=4, ack 3 cycles after each req, data 0x000123,0xFFFFFE,0x7FFFFF,0x800000 -> raw writes ch0..3 = 0x00000123,0xFFFFFFFE,0x007FFFFF,0xFF800000; one done_o; seq_cnt_o=1.
REQ-037 cfg_num_ch=0 then 12 -> sequences of 1 and 8 channels respectively.
REQ-038 cfg_period=100, enable, immediate ack -> sequence starts every 100 cycles; enable=0 -> no further starts.
REQ-039 Three ctrl_start pulses during a busy sequence -> exactly one extra sequence follows; seq_cnt_o +2 total.
REQ-040 HI_ADC_SEQ_TIMEOUT_EN defined, TIMEOUT_CYC=16, no ack on ch1 -> err_timeout_o pulse 16 cycles after req, busy_o low, seq_cnt_o unchanged.
REQ-041 wb_rst_ni asserted during REQ on ch2 -> all outputs 0 asynchronously; next ctrl_start restarts at ch0.

Source files
------------

// File: rtl/adc_capture_seq_if.sv
// ADC conversion handshake between the capture sequencer (master) and the converter (slave).
// The sequencer raises adc_req_o for adc_ch_o; the converter returns a one-cycle ack with the sample.
interface adc_capture_seq_if #(
    parameter int DATA_W = 24
) ();
    logic              adc_req_o;
    logic [2:0]        adc_ch_o;
    logic              adc_ack_i;
    logic [DATA_W-1:0] adc_data_i;

    modport master (
        output adc_req_o,
        output adc_ch_o,
        input  adc_ack_i,
        input  adc_data_i
    );

    modport slave (
        input  adc_req_o,
        input  adc_ch_o,
        output adc_ack_i,
        output adc_data_i
    );
endinterface

// File: rtl/adc_capture_seq.sv
// ADC capture sequencer: scans channels 0..n-1 per trigger and writes sign-extended samples out.
// Define HI_ADC_SEQ_TIMEOUT_EN to add an ack watchdog on the REQ state.
module adc_capture_seq #(
    parameter int NCH_MAX     = 8,
    parameter int DATA_W      = 24,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              ctrl_enable,
    input  logic              ctrl_start,
    input  logic [3:0]        cfg_num_ch,
    input  logic [15:0]       cfg_period,
    adc_capture_seq_if.master adc,
    output logic              raw_we_o,
    output logic [2:0]        raw_ch_o,
    output logic [31:0]       raw_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_timeout_o,
    output logic [15:0]       seq_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WRITE,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [15:0]              timer;
    logic                     period_tick;
    logic                     pending;
    logic                     trigger;
    logic [3:0]               n_eff;
    logic [3:0]               n_lat;
    logic [2:0]               ch;
    logic                     last_ch;
    logic                     wd_expire;
    logic signed [DATA_W-1:0] sample_p0;
    logic [15:0]              seq_cnt;

    function automatic logic [31:0] sign_ext(input logic signed [DATA_W-1:0] s);
        logic signed [31:0] w;
        w = 32'(s);
        return w;
    endfunction

    assign period_tick = ctrl_enable && (cfg_period != 16'd0) && (timer == cfg_period - 16'd1);
    assign trigger     = ctrl_enable && (ctrl_start || period_tick || pending);
    assign last_ch     = ({1'b0, ch} == (n_lat - 4'd1));
    assign seq_cnt_o   = seq_cnt;

    // Zero requests a single channel; oversize requests clamp to the hardware maximum.
    always_comb begin
        if (cfg_num_ch == 4'd0) begin
            n_eff = 4'd1;
        end else if (int'(cfg_num_ch) > NCH_MAX) begin
            n_eff = 4'(NCH_MAX);
        end else begin
            n_eff = cfg_num_ch;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        adc.adc_req_o  = 1'b0;
        adc.adc_ch_o   = 3'd0;
        raw_we_o       = 1'b0;
        raw_ch_o       = 3'd0;
        raw_data_o     = 32'd0;
        busy_o         = (state != IDLE);
        done_o         = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) state_nxt = REQ;
            end
            REQ: begin
                adc.adc_req_o = 1'b1;
                adc.adc_ch_o  = ch;
                if (adc.adc_ack_i) begin
                    state_nxt = WRITE;
                end else if (wd_expire) begin
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                raw_we_o   = 1'b1;
                raw_ch_o   = ch;
                raw_data_o = sign_ext(sample_p0);
                state_nxt  = last_ch ? DONE : REQ;
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            timer     <= 16'd0;
            pending   <= 1'b0;
            n_lat     <= 4'd0;
            ch        <= 3'd0;
            sample_p0 <= '0;
            seq_cnt   <= 16'd0;
        end else begin
            if (ctrl_enable && (cfg_period != 16'd0)) begin
                timer <= period_tick ? 16'd0 : timer + 16'd1;
            end else begin
                timer <= 16'd0;
            end

            // Triggers arriving while busy collapse into one deferred sequence.
            if (!ctrl_enable || (state == IDLE)) begin
                pending <= 1'b0;
            end else if (ctrl_start || period_tick) begin
                pending <= 1'b1;
            end

            if ((state == IDLE) && trigger) begin
                n_lat <= n_eff;
                ch    <= 3'd0;
            end

            // Stage p0: sample captured on ack, presented during WRITE.
            if ((state == REQ) && adc.adc_ack_i) begin
                sample_p0 <= $signed(adc.adc_data_i);
            end

            if (state == WRITE) begin
                ch <= last_ch ? 3'd0 : ch + 3'd1;
            end

            if (state == DONE) begin
                seq_cnt <= seq_cnt + 16'd1;
            end
        end
    end

`ifdef HI_ADC_SEQ_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [WD_W-1:0] wd;
    logic            err;

    assign wd_expire     = (state == REQ) && !adc.adc_ack_i && (wd == WD_W'(TIMEOUT_CYC - 1));
    assign err_timeout_o = err;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wd  <= '0;
            err <= 1'b0;
        end else begin
            err <= wd_expire;
            wd  <= (state == REQ) ? wd + WD_W'(1) : '0;
        end
    end
`else
    assign wd_expire     = 1'b0;
    assign err_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_adc_capture_seq.sv
// Scoreboard bench for adc_capture_seq: an ADC responder pushes expected raw writes, a monitor pops them.
`timescale 1ns/1ps
module tb_adc_capture_seq;
    localparam int DATA_W      = 24;
    localparam int NCH_MAX     = 8;
    localparam int TIMEOUT_CYC = 16;

    typedef struct {
        logic [2:0]  ch;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [23:0] raw;
        logic [31:0] ext;
    } smp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ctrl_enable = 1'b0;
    logic        ctrl_start = 1'b0;
    logic [3:0]  cfg_num_ch = 4'd0;
    logic [15:0] cfg_period = 16'd0;
    logic        raw_we;
    logic [2:0]  raw_ch;
    logic [31:0] raw_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] seq_cnt;

    adc_capture_seq_if #(.DATA_W(DATA_W)) adc ();

    adc_capture_seq #(
        .NCH_MAX    (NCH_MAX),
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .ctrl_enable  (ctrl_enable),
        .ctrl_start   (ctrl_start),
        .cfg_num_ch   (cfg_num_ch),
        .cfg_period   (cfg_period),
        .adc          (adc),
        .raw_we_o     (raw_we),
        .raw_ch_o     (raw_ch),
        .raw_data_o   (raw_data),
        .busy_o       (busy),
        .done_o       (done),
        .err_timeout_o(err),
        .seq_cnt_o    (seq_cnt)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    wr_t  exp_q[$];
    smp_t smp_q[$];
    int   start_q[$];
    int   wr_cnt = 0, done_cnt = 0, start_cnt = 0, err_cnt = 0, err_cyc = 0;
    int   ack_delay = 0, model_n = 1, model_ch = 0, no_ack_ch = -1;
    int   req_rise_cyc = 0;
    bit   stray_ack = 1'b0;
    int   exp_seq = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_req"},      32'(adc.adc_req_o), 32'd0);
        check_val({tag, "_adc_ch"},   32'(adc.adc_ch_o),  32'd0);
        check_val({tag, "_raw_we"},   32'(raw_we),        32'd0);
        check_val({tag, "_raw_ch"},   32'(raw_ch),        32'd0);
        check_val({tag, "_raw_data"}, raw_data,           32'd0);
        check_val({tag, "_busy"},     32'(busy),          32'd0);
        check_val({tag, "_done"},     32'(done),          32'd0);
        check_val({tag, "_err"},      32'(err),           32'd0);
        check_val({tag, "_seq_cnt"},  32'(seq_cnt),       32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        ctrl_start = 1'b1;
        @(negedge clk);
        ctrl_start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check_val("done_reached", done_cnt, target);
    endtask

    task automatic push_sample(input logic [23:0] raw, input logic [31:0] ext);
        smp_t s;
        s.raw = raw;
        s.ext = ext;
        smp_q.push_back(s);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ADC responder: acks after ack_delay idle cycles and records what the sequencer must write.
    initial begin
        wr_t  e;
        smp_t s;
        int   wait_cnt;
        bit   req_prev;
        wait_cnt = 0;
        req_prev = 1'b0;
        adc.adc_ack_i  = 1'b0;
        adc.adc_data_i = '0;
        forever begin
            @(negedge clk);
            if (adc.adc_req_o && !req_prev) req_rise_cyc = cyc;
            req_prev = adc.adc_req_o;
            if (!rst_n) begin
                adc.adc_ack_i = 1'b0;
                wait_cnt = 0;
            end else if (adc.adc_ack_i) begin
                adc.adc_ack_i = 1'b0;
            end else if (!adc.adc_req_o) begin
                wait_cnt = 0;
                if (stray_ack) begin
                    adc.adc_ack_i  = 1'b1;
                    adc.adc_data_i = 24'h5A5A5A;
                    stray_ack = 1'b0;
                end
            end else if (int'(adc.adc_ch_o) != no_ack_ch) begin
                if (wait_cnt >= ack_delay) begin
                    if (smp_q.size() > 0) begin
                        s = smp_q.pop_front();
                    end else begin
                        s.raw = 24'($urandom);
                        s.ext = {{8{s.raw[23]}}, s.raw};
                    end
                    check_val("adc_ch", 32'(adc.adc_ch_o), model_ch);
                    e.ch   = 3'(model_ch);
                    e.data = s.ext;
                    exp_q.push_back(e);
                    model_ch = (model_ch + 1 == model_n) ? 0 : model_ch + 1;
                    adc.adc_ack_i  = 1'b1;
                    adc.adc_data_i = s.raw;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    initial begin
        wr_t e;
        bit  busy_prev;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (raw_we) begin
                    wr_cnt++;
                    check_val("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_val("raw_ch", 32'(raw_ch), 32'(e.ch));
                        check_val("raw_data", raw_data, e.data);
                    end
                end
                if (done) done_cnt++;
                if (busy && !busy_prev) begin
                    start_cnt++;
                    start_q.push_back(cyc);
                end
                if (err) begin
                    err_cnt++;
                    err_cyc = cyc;
                end
            end
            busy_prev = busy;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got cyc=%0d expected completion", cyc);
        $fatal(1, "bench time limit");
    end

    initial begin
        int s0, d0, w0, e0, n;
        bit found;

        // Reset state and quiet outputs after release
        repeat (3) @(negedge clk);
        check_idle_outputs("rst");
        rst_n = 1'b1;
        ctrl_enable = 1'b1;
        cfg_num_ch = 4'd4;
        repeat (10) @(negedge clk);
        check_val("post_rst_busy", 32'(busy), 32'd0);
        check_val("post_rst_req", 32'(adc.adc_req_o), 32'd0);

        // Four channels, slow ack, sign-extension boundary samples
        model_n = 4; model_ch = 0; ack_delay = 3;
        push_sample(24'h000123, 32'h00000123);
        push_sample(24'hFFFFFE, 32'hFFFFFFFE);
        push_sample(24'h7FFFFF, 32'h007FFFFF);
        push_sample(24'h800000, 32'hFF800000);
        w0 = wr_cnt;
        pulse_start();
        wait_done(1, 200);
        exp_seq = 1;
        check_val("seq4_writes", wr_cnt - w0, 4);
        check_val("seq4_seq_cnt", 32'(seq_cnt), exp_seq);

        // Ack while idle must be ignored
        w0 = wr_cnt; s0 = start_cnt;
        stray_ack = 1'b1;
        repeat (6) @(negedge clk);
        check_val("stray_writes", wr_cnt - w0, 0);
        check_val("stray_starts", start_cnt - s0, 0);

        // Channel count clamping: 0 -> 1, 12 -> NCH_MAX
        cfg_num_ch = 4'd0; model_n = 1; model_ch = 0; ack_delay = 1;
        w0 = wr_cnt;
        pulse_start();
        wait_done(2, 100);
        check_val("n0_writes", wr_cnt - w0, 1);
        cfg_num_ch = 4'd12; model_n = 8; model_ch = 0;
        w0 = wr_cnt;
        pulse_start();
        wait_done(3, 300);
        check_val("n12_writes", wr_cnt - w0, 8);
        exp_seq += 2;
        check_val("clamp_seq_cnt", 32'(seq_cnt), exp_seq);

        // Auto-trigger every 100 cycles, stops when disabled
        cfg_num_ch = 4'd1; model_n = 1; model_ch = 0; ack_delay = 0;
        s0 = start_q.size();
        cfg_period = 16'd100;
        n = 0;
        while (start_q.size() < s0 + 4 && n < 600) begin
            @(negedge clk);
            n++;
        end
        ctrl_enable = 1'b0;
        check_val("period_starts", start_q.size() - s0, 4);
        if (start_q.size() >= s0 + 4) begin
            for (int i = 1; i < 4; i++) begin
                check_val("period_gap", start_q[s0 + i] - start_q[s0 + i - 1], 100);
            end
        end
        s0 = start_cnt;
        repeat (350) @(negedge clk);
        check_val("disabled_no_start", start_cnt - s0, 0);
        exp_seq += 4;
        check_val("period_seq_cnt", 32'(seq_cnt), exp_seq);
        cfg_period = 16'd0;
        @(negedge clk);
        ctrl_enable = 1'b1;

        // Manual start coinciding with a period tick gives one sequence only
        s0 = start_cnt;
        cfg_period = 16'd20;
        repeat (19) @(negedge clk);
        ctrl_start = 1'b1;
        @(negedge clk);
        ctrl_start = 1'b0;
        cfg_period = 16'd0;
        repeat (40) @(negedge clk);
        check_val("start_tick_single", start_cnt - s0, 1);
        exp_seq += 1;

        // Three starts while busy collapse into one extra sequence
        cfg_num_ch = 4'd4; model_n = 4; model_ch = 0; ack_delay = 3;
        s0 = start_cnt; d0 = done_cnt;
        pulse_start();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            pulse_start();
            @(negedge clk);
        end
        wait_done(d0 + 2, 400);
        repeat (40) @(negedge clk);
        check_val("pending_starts", start_cnt - s0, 2);
        exp_seq += 2;
        check_val("pending_seq_cnt", 32'(seq_cnt), exp_seq);

        // Disable mid-sequence: sequence completes, start while disabled is dropped
        s0 = start_cnt; d0 = done_cnt;
        pulse_start();
        repeat (5) @(negedge clk);
        ctrl_enable = 1'b0;
        pulse_start();
        wait_done(d0 + 1, 200);
        ctrl_enable = 1'b1;
        repeat (40) @(negedge clk);
        check_val("disable_mid_starts", start_cnt - s0, 1);
        exp_seq += 1;
        check_val("disable_mid_seq_cnt", 32'(seq_cnt), exp_seq);

`ifdef HI_ADC_SEQ_TIMEOUT_EN
        // Watchdog: no ack on ch1
        model_ch = 0; ack_delay = 0; no_ack_ch = 1;
        e0 = err_cnt; w0 = wr_cnt;
        pulse_start();
        n = 0;
        while (err_cnt == e0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("timeout_pulses", err_cnt - e0, 1);
        check_val("timeout_latency", err_cyc - req_rise_cyc, TIMEOUT_CYC);
        check_val("timeout_busy", 32'(busy), 32'd0);
        repeat (30) @(negedge clk);
        check_val("timeout_writes", wr_cnt - w0, 1);
        check_val("timeout_seq_cnt", 32'(seq_cnt), exp_seq);
        check_val("timeout_single", err_cnt - e0, 1);
        no_ack_ch = -1; model_ch = 0;
`else
        e0 = err_cnt;
        check_val("err_never", e0, 0);
`endif

        // Asynchronous reset while requesting ch2, then restart from ch0
        cfg_num_ch = 4'd4; model_n = 4; model_ch = 0; ack_delay = 1; no_ack_ch = 2;
        pulse_start();
        found = 1'b0;
        n = 0;
        while (!found && n < 100) begin
            @(negedge clk);
            found = adc.adc_req_o && (adc.adc_ch_o == 3'd2);
            n++;
        end
        check_val("reached_ch2", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        no_ack_ch = -1; model_ch = 0;
        exp_q.delete();
        repeat (5) @(negedge clk);
        check_val("rst_quiet_busy", 32'(busy), 32'd0);
        d0 = done_cnt;
        pulse_start();
        wait_done(d0 + 1, 200);
        check_val("rst_restart_seq_cnt", 32'(seq_cnt), 32'd1);

        check_val("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
